flash_burst_arbiter: RTL and testbench

//  Shares one dspi_flash_reader (single-byte read/ready handshake) between two requesters.

---
 rtl/flash_burst_arbiter_pkg.sv | 19 +
 rtl/flash_burst_arbiter_rr_arb2.sv | 14 +
 rtl/flash_burst_arbiter.sv | 165 ++++++++++++++++
 tb/tb_flash_burst_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_burst_arbiter_pkg.sv
// rtl/flash_burst_arbiter_pkg.sv - shared encodings and constants for the flash burst arbiter
package flash_burst_arbiter_pkg;

  localparam int ADDR_W = 24;
  localparam logic [ADDR_W-1:0] FLASH_DATA_BASE = 24'h400000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Byte address increment; wraps FFFFFF -> 000000 by width truncation.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + 24'd1;
  endfunction

endpackage

// File: rtl/flash_burst_arbiter_rr_arb2.sv
// rtl/flash_burst_arbiter_rr_arb2.sv - two-way round-robin picker
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = valid[0] | valid[1];
    grant     = valid[prio] ? prio : ~prio;
  end

endmodule

// File: rtl/flash_burst_arbiter.sv
// rtl/flash_burst_arbiter.sv - shares one byte-wide flash reader between two burst requesters
module flash_burst_arbiter
  import flash_burst_arbiter_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [23:0]      req0_addr,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_accept,
  input  logic             req1_valid,
  input  logic [23:0]      req1_addr,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_accept,
  output logic             rd0_valid,
  output logic [7:0]       rd0_data,
  output logic             rd0_last,
  input  logic             rd0_ready,
  output logic             rd1_valid,
  output logic [7:0]       rd1_data,
  output logic             rd1_last,
  input  logic             rd1_ready,
  output logic             err0,
  output logic             err1,
  output logic             fl_read,
  output logic [23:0]      fl_addr,
  input  logic             fl_ready,
  input  logic [7:0]       fl_data
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  state_t             state;
  state_t             state_nxt;
  logic               prio;
  logic               grant;
  logic [23:0]        cur_addr;
  logic [LEN_W-1:0]   remain;
  logic [7:0]         hold;
  logic [TMO_W-1:0]   tmo;

  logic               arb_grant;
  logic               arb_valid;
  logic               sel_ready;
  logic               timed_out;
  logic [23:0]        sel_addr;
  logic [LEN_W-1:0]   sel_len;

  rr_arb2 u_arb (
    .valid     ({req1_valid, req0_valid}),
    .prio      (prio),
    .grant     (arb_grant),
    .gnt_valid (arb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fl_read   = 1'b0;
    timed_out = 1'b0;
    rd0_valid = 1'b0;
    rd1_valid = 1'b0;
    rd0_data  = 8'd0;
    rd1_data  = 8'd0;
    rd0_last  = 1'b0;
    rd1_last  = 1'b0;
    sel_ready = grant ? rd1_ready : rd0_ready;
    sel_addr  = arb_grant ? req1_addr : req0_addr;
    sel_len   = arb_grant ? req1_len : req0_len;
    case (state)
      ST_IDLE: begin
        if (arb_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        fl_read   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (fl_ready) begin
          state_nxt = ST_HOLD;
        end else if (tmo == TMO_MAX) begin
          timed_out = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Only the granted port ever sees a beat; the other stays silent.
        rd0_valid = ~grant;
        rd1_valid = grant;
        rd0_data  = grant ? 8'd0 : hold;
        rd1_data  = grant ? hold : 8'd0;
        rd0_last  = ~grant & (remain == '0);
        rd1_last  = grant & (remain == '0);
        if (sel_ready) state_nxt = (remain == '0) ? ST_IDLE : ST_ISSUE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    err0 = timed_out & ~grant;
    err1 = timed_out & grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio        <= 1'b0;
      grant       <= 1'b0;
      cur_addr    <= 24'd0;
      remain      <= '0;
      hold        <= 8'd0;
      tmo         <= '0;
      fl_addr     <= 24'd0;
      req0_accept <= 1'b0;
      req1_accept <= 1'b0;
    end else begin
      req0_accept <= 1'b0;
      req1_accept <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant       <= arb_grant;
            cur_addr    <= sel_addr;
            remain      <= sel_len;
            fl_addr     <= sel_addr;
            req0_accept <= ~arb_grant;
            req1_accept <= arb_grant;
          end
        end
        ST_ISSUE: begin
          tmo <= '0;
        end
        ST_WAIT: begin
          if (fl_ready) begin
            hold <= fl_data;
          end else begin
            tmo <= tmo + 1'b1;
            if (tmo == TMO_MAX) prio <= ~grant;
          end
        end
        ST_HOLD: begin
          if (sel_ready) begin
            if (remain == '0) begin
              prio <= ~grant;
            end else begin
              cur_addr <= next_addr(cur_addr);
              fl_addr  <= next_addr(cur_addr);
              remain   <= remain - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_burst_arbiter.sv
// tb/tb_flash_burst_arbiter.sv - directed self-checking bench for flash_burst_arbiter
module tb_flash_burst_arbiter;
  import flash_burst_arbiter_pkg::*;

  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 255;

  logic clk;
  logic rst;
  logic req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic [LEN_W-1:0] req0_len, req1_len;
  logic req0_accept, req1_accept;
  logic rd0_valid, rd1_valid, rd0_last, rd1_last, rd0_ready, rd1_ready;
  logic [7:0] rd0_data, rd1_data;
  logic err0, err1, fl_read, fl_ready;
  logic [23:0] fl_addr;
  logic [7:0] fl_data;

  flash_burst_arbiter #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_accept(req0_accept),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_accept(req1_accept),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data), .rd0_last(rd0_last), .rd0_ready(rd0_ready),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data), .rd1_last(rd1_last), .rd1_ready(rd1_ready),
    .err0(err0), .err1(err1),
    .fl_read(fl_read), .fl_addr(fl_addr), .fl_ready(fl_ready), .fl_data(fl_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reader model: ready pulse 28 cycles after the read strobe, data = addr[7:0]^A5.
  int rd_cnt = 0;
  logic [23:0] rd_lat = 24'd0;
  bit silent = 1'b0;
  initial begin
    fl_ready = 1'b0;
    fl_data  = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      fl_ready = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          fl_ready = 1'b1;
          fl_data  = rd_lat[7:0] ^ 8'hA5;
        end
      end
      if (fl_read && !silent) begin
        rd_cnt = 28;
        rd_lat = fl_addr;
      end
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [23:0] read_q[$];
  int last_read_cyc = 0;
  int dbl = 0;
  bit prev_read = 1'b0;
  initial forever begin
    @(negedge clk);
    if (fl_read) begin
      read_q.push_back(fl_addr);
      last_read_cyc = cyc;
      if (prev_read) dbl++;
    end
    prev_read = fl_read;
  end

  logic [7:0] cap_d[$];

  task automatic post(input int p, input logic [23:0] a, input logic [7:0] l);
    if (p == 0) begin
      req0_addr = a; req0_len = l; req0_valid = 1'b1;
    end else begin
      req1_addr = a; req1_len = l; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input int p);
    int c;
    bit stray;
    c = 0;
    stray = 1'b0;
    while (c < 100 && !(p == 1 ? req1_accept : req0_accept)) begin
      if (p == 1 ? req0_accept : req1_accept) stray = 1'b1;
      @(negedge clk);
      c++;
    end
    chk($sformatf("accept%0d_seen", p), 32'(c < 100), 1);
    chk($sformatf("accept%0d_other_quiet", p), 32'(stray | (p == 1 ? req0_accept : req1_accept)), 0);
    if (p == 1) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("accept%0d_one_cycle", p), 32'(p == 1 ? req1_accept : req0_accept), 0);
  endtask

  task automatic collect(input int p, input int n);
    cap_d.delete();
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      while (c < 100 && !(p == 1 ? rd1_valid : rd0_valid)) begin
        @(negedge clk);
        c++;
      end
      chk($sformatf("p%0d_beat%0d_seen", p, i), 32'(c < 100), 1);
      if (c >= 100) return;
      cap_d.push_back(p == 1 ? rd1_data : rd0_data);
      chk($sformatf("p%0d_beat%0d_last", p, i), 32'(p == 1 ? rd1_last : rd0_last), 32'(i == n - 1));
      chk($sformatf("p%0d_beat%0d_other_idle", p, i), 32'(p == 1 ? rd0_valid : rd1_valid), 0);
      @(negedge clk);
    end
  endtask

  task automatic chk_cap(input string name, input int idx, input logic [7:0] exp);
    if (idx < cap_d.size()) chk(name, 32'(cap_d[idx]), 32'(exp));
    else chk(name, 32'hFFFF_FFFF, 32'(exp));
  endtask

  typedef struct {
    int               port;
    logic [23:0]      addr;
    logic [7:0]       len;
    logic [0:3][7:0]  d;
    logic [0:3][23:0] fa;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;
    int bad;
    int seen;
    logic [23:0] a0;

    vecs[0] = '{0, FLASH_DATA_BASE, 8'd3, {8'hA5, 8'hA4, 8'hA7, 8'hA6},
                {24'h400000, 24'h400001, 24'h400002, 24'h400003}};
    vecs[1] = '{1, 24'hFFFFFE, 8'd3, {8'h5B, 8'h5A, 8'hA5, 8'hA4},
                {24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001}};
    vecs[2] = '{1, 24'h400010, 8'd0, {8'hB5, 8'h00, 8'h00, 8'h00},
                {24'h400010, 24'h0, 24'h0, 24'h0}};
    vecs[3] = '{0, 24'h1234FF, 8'd1, {8'h5A, 8'hA5, 8'h00, 8'h00},
                {24'h1234FF, 24'h123500, 24'h0, 24'h0}};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = 24'd0; req1_addr = 24'd0;
    req0_len = '0; req1_len = '0;
    rd0_ready = 1'b1; rd1_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {fl_addr, fl_read, err0, err1, req0_accept, req1_accept, rd0_valid, rd1_valid}, 0);
    chk("reset_rd_data", {rd0_data, rd1_data, 6'd0, rd0_last, rd1_last}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests alternate starting from prio=0.
    for (int r = 0; r < 4; r++) begin
      a0 = 24'h400020 + 24'(2 * r);
      post(0, a0, 8'd0);
      post(1, a0 + 24'd1, 8'd0);
      wait_accept(0);
      collect(0, 1);
      chk_cap($sformatf("rr%0d_p0_data", r), 0, a0[7:0] ^ 8'hA5);
      wait_accept(1);
      collect(1, 1);
      chk_cap($sformatf("rr%0d_p1_data", r), 0, (a0[7:0] + 8'd1) ^ 8'hA5);
    end

    for (int k = 0; k < 4; k++) begin
      base = read_q.size();
      post(vecs[k].port, vecs[k].addr, vecs[k].len);
      wait_accept(vecs[k].port);
      collect(vecs[k].port, int'(vecs[k].len) + 1);
      for (int i = 0; i <= int'(vecs[k].len); i++) begin
        chk_cap($sformatf("v%0d_data%0d", k, i), i, vecs[k].d[i]);
        if (base + i < read_q.size())
          chk($sformatf("v%0d_fl_addr%0d", k, i), 32'(read_q[base + i]), 32'(vecs[k].fa[i]));
        else
          chk($sformatf("v%0d_fl_addr%0d", k, i), 32'hFFFF_FFFF, 32'(vecs[k].fa[i]));
      end
      chk($sformatf("v%0d_read_count", k), 32'(read_q.size() - base), 32'(int'(vecs[k].len) + 1));
    end

    // Backpressure in HOLD: beat, address and strobe must all freeze.
    rd0_ready = 1'b0;
    post(0, 24'h400030, 8'd1);
    wait_accept(0);
    c = 0;
    while (c < 100 && !rd0_valid) begin
      @(negedge clk);
      c++;
    end
    chk("bp_first_beat_seen", 32'(c < 100), 1);
    base = read_q.size();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rd0_valid || rd0_data !== 8'h95 || fl_read || fl_addr !== 24'h400030) bad++;
      @(negedge clk);
    end
    chk("bp_hold_stable", 32'(bad), 0);
    chk("bp_no_new_read", 32'(read_q.size() - base), 0);
    rd0_ready = 1'b1;
    collect(0, 2);
    chk_cap("bp_data0", 0, 8'h95);
    chk_cap("bp_data1", 1, 8'h94);

    // Silent reader: timeout error, then the pending request on port 1 is served.
    silent = 1'b1;
    post(0, 24'h400040, 8'd2);
    wait_accept(0);
    post(1, 24'h400050, 8'd0);
    c = 0;
    bad = 0;
    while (c < 400 && !err0) begin
      @(negedge clk);
      c++;
      if (rd0_valid) bad++;
    end
    chk("tmo_err_seen", 32'(c < 400), 1);
    chk("tmo_err_delay", 32'(cyc - last_read_cyc), 32'(TIMEOUT + 1));
    chk("tmo_err1_quiet", 32'(err1), 0);
    chk("tmo_no_rd_valid", 32'(bad), 0);
    silent = 1'b0;
    @(negedge clk);
    chk("tmo_err_one_cycle", 32'(err0), 0);
    wait_accept(1);
    collect(1, 1);
    chk_cap("tmo_next_p1_data", 0, 8'hF5);

    // Reset in WAIT: outputs drop immediately, the reader's late ready is ignored.
    post(0, 24'h400060, 8'd0);
    wait_accept(0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {fl_addr, fl_read, err0, err1, req0_accept, req1_accept, rd0_valid, rd1_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fl_ready) seen++;
      if (rd0_valid || rd1_valid || fl_read || req0_accept || req1_accept) bad++;
    end
    chk("rst_stray_ready_seen", 32'(seen > 0), 1);
    chk("rst_stray_ignored", 32'(bad), 0);
    post(0, 24'h400070, 8'd1);
    wait_accept(0);
    collect(0, 2);
    chk_cap("rst_after_data0", 0, 8'hD5);
    chk_cap("rst_after_data1", 1, 8'hD4);

    chk("fl_read_single_cycle", 32'(dbl), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
